serial_marker_tx: RTL and testbench

Transmit side of the serial marker link. Accepts a parallel word through a valid/ready handshake and sends it MSB-first on a single-bit line as one frame: a 4-bit sync marker (default 1001), then DATA_W data bits, then an optional even-parity bit, then idle zeros. Sits upstream of the Moore non-overlapping marker detector, which qualifies frame starts on the far end. All outputs are registered (Moore), so the line is glitch-free.

---
 rtl/serial_marker_tx.sv | 149 ++++++++++++++
 tb/tb_serial_marker_tx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_marker_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_marker_tx
// Brief    : Serializes one parallel word per frame (sync marker, data MSB-first,
//            optional even parity, forced idle zeros) with registered outputs.
// Revision : 1.0 - initial release
// ============================================================================
module serial_marker_tx #(
    parameter int         DATA_W    = 8,
    parameter logic [3:0] MARKER    = 4'b1001,
    parameter int         PARITY_EN = 1,
    parameter int         IDLE_BITS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              dout,
    output logic              busy,
    output logic              frame_done
);

    localparam int c_MAX_MD  = (DATA_W > 4) ? DATA_W : 4;
    localparam int c_CNT_MAX = (IDLE_BITS > c_MAX_MD) ? IDLE_BITS : c_MAX_MD;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_MARK_LAST = c_CNT_W'(3);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(IDLE_BITS - 1);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_MARK = 3'd1;
    localparam logic [2:0] c_ST_DATA = 3'd2;
    localparam logic [2:0] c_ST_PAR  = 3'd3;
    localparam logic [2:0] c_ST_GAP  = 3'd4;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_count;
    logic [DATA_W-1:0]  r_shift;
    logic               r_parity;
    logic               r_dout;
    logic               r_ready;
    logic               r_busy;
    logic               r_frame_done;

    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [DATA_W-1:0]  w_shift_nxt;
    logic               w_parity_nxt;
    logic               w_dout_nxt;
    logic               w_ready_nxt;
    logic               w_busy_nxt;
    logic               w_frame_done_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_count      <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_dout       <= 1'b0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_shift      <= w_shift_nxt;
            r_parity     <= w_parity_nxt;
            r_dout       <= w_dout_nxt;
            r_ready      <= w_ready_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;
        case (r_state)
            c_ST_IDLE: begin
                if (data_valid && r_ready) begin
                    w_state_nxt  = c_ST_MARK;
                    w_count_nxt  = '0;
                    w_shift_nxt  = data_in;
                    w_parity_nxt = ^data_in;
                end
            end
            c_ST_MARK: begin
                if (r_count == c_MARK_LAST) begin
                    w_state_nxt = c_ST_DATA;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            c_ST_DATA: begin
                w_shift_nxt = r_shift << 1;
                if (r_count == c_DATA_LAST) begin
                    w_state_nxt = (PARITY_EN != 0) ? c_ST_PAR : c_ST_GAP;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            c_ST_PAR: begin
                w_state_nxt = c_ST_GAP;
                w_count_nxt = '0;
            end
            c_ST_GAP: begin
                if (r_count == c_GAP_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered and
    // still line up with the state they describe.
    always_comb begin
        w_dout_nxt       = 1'b0;
        w_ready_nxt      = (w_state_nxt == c_ST_IDLE);
        w_busy_nxt       = (w_state_nxt != c_ST_IDLE);
        w_frame_done_nxt = (w_state_nxt == c_ST_GAP) && (w_count_nxt == c_GAP_LAST);
        case (w_state_nxt)
            c_ST_MARK: w_dout_nxt = MARKER[~w_count_nxt[1:0]];
            c_ST_DATA: w_dout_nxt = w_shift_nxt[DATA_W-1];
            c_ST_PAR:  w_dout_nxt = w_parity_nxt;
            default:   w_dout_nxt = 1'b0;
        endcase
    end

    assign dout       = r_dout;
    assign data_ready = r_ready;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_marker_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_marker_tx
// Brief    : Scoreboard bench for serial_marker_tx (parity and no-parity builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_marker_tx;

    localparam int         DATA_W    = 8;
    localparam int         IDLE_BITS = 1;
    localparam logic [3:0] MARKER    = 4'b1001;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] data_in = '0;
    logic              data_valid = 1'b0;
    logic              data_ready, dout, busy, frame_done;
    logic [DATA_W-1:0] data_in_np = '0;
    logic              data_valid_np = 1'b0;
    logic              data_ready_np, dout_np, busy_np, frame_done_np;

    typedef struct packed {
        logic d;
        logic fd;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_marker_tx #(.DATA_W(DATA_W), .MARKER(MARKER), .PARITY_EN(1), .IDLE_BITS(IDLE_BITS)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .dout(dout), .busy(busy), .frame_done(frame_done)
    );

    serial_marker_tx #(.DATA_W(DATA_W), .MARKER(MARKER), .PARITY_EN(0), .IDLE_BITS(IDLE_BITS)) dut_np (
        .clk(clk), .reset(reset), .data_in(data_in_np), .data_valid(data_valid_np),
        .data_ready(data_ready_np), .dout(dout_np), .busy(busy_np), .frame_done(frame_done_np)
    );

    // Expected line contents for one frame: marker, data MSB-first, parity, gap.
    task automatic push_frame(input logic [DATA_W-1:0] w, input bit par);
        exp_t e;
        e.fd = 1'b0;
        for (int i = 3; i >= 0; i--) begin e.d = MARKER[i]; exp_q.push_back(e); end
        for (int i = DATA_W - 1; i >= 0; i--) begin e.d = w[i]; exp_q.push_back(e); end
        if (par) begin e.d = ^w; exp_q.push_back(e); end
        for (int i = 0; i < IDLE_BITS; i++) begin
            e.d  = 1'b0;
            e.fd = (i == IDLE_BITS - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1; data_valid = 1'b1; data_in = 8'h81;
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if ({dout, busy, data_ready, frame_done} !== 4'b0010) begin
                n_err++;
                $display("FAIL reset_state: got dout/busy/ready/done=%b want 0010",
                         {dout, busy, data_ready, frame_done});
            end
        end
        reset = 1'b0;
        @(posedge clk);
        push_frame(8'h81, 1'b1);
        @(negedge clk);
        data_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if ({dout, frame_done, busy, data_ready} !== {e.d, e.fd, 2'b10}) begin
                n_err++;
                $display("FAIL reset_release bit%0d: got %b want %b", i,
                         {dout, frame_done, busy, data_ready}, {e.d, e.fd, 2'b10});
            end
        end
    endtask

    task automatic test_single(input logic [DATA_W-1:0] w, input string name);
        exp_t e;
        @(negedge clk);
        data_in = w; data_valid = 1'b1;
        @(posedge clk);
        push_frame(w, 1'b1);
        @(negedge clk);
        data_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if ({dout, frame_done, busy, data_ready} !== {e.d, e.fd, 2'b10}) begin
                n_err++;
                $display("FAIL %s bit%0d: got dout/done/busy/ready=%b want %b", name, i,
                         {dout, frame_done, busy, data_ready}, {e.d, e.fd, 2'b10});
            end
        end
        @(negedge clk);
        n_vec++;
        if ({dout, frame_done, busy, data_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL %s idle_after: got %b want 0001", name,
                     {dout, frame_done, busy, data_ready});
        end
    endtask

    task automatic test_parity();
        test_single(8'h01, "parity_01");
        test_single(8'hFF, "parity_FF");
    endtask

    task automatic test_no_parity();
        exp_t e;
        @(negedge clk);
        data_in_np = 8'h01; data_valid_np = 1'b1;
        @(posedge clk);
        push_frame(8'h01, 1'b0);
        @(negedge clk);
        data_valid_np = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i > 0) @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if ({dout_np, frame_done_np, busy_np, data_ready_np} !== {e.d, e.fd, 2'b10}) begin
                n_err++;
                $display("FAIL no_parity bit%0d: got %b want %b", i,
                         {dout_np, frame_done_np, busy_np, data_ready_np}, {e.d, e.fd, 2'b10});
            end
        end
        @(negedge clk);
        n_vec++;
        if ({dout_np, frame_done_np, busy_np, data_ready_np} !== 4'b0001) begin
            n_err++;
            $display("FAIL no_parity idle_after: got %b want 0001",
                     {dout_np, frame_done_np, busy_np, data_ready_np});
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic exp_busy;
        @(negedge clk);
        data_in = 8'h3C; data_valid = 1'b1;
        @(posedge clk);
        push_frame(8'h3C, 1'b1);
        e.d = 1'b0; e.fd = 1'b0;
        exp_q.push_back(e);
        push_frame(8'hC3, 1'b1);
        @(negedge clk);
        data_in = 8'hC3;
        for (int i = 0; i < 29; i++) begin
            if (i > 0) @(negedge clk);
            e = exp_q.pop_front();
            exp_busy = (i != 14);
            n_vec++;
            if ({dout, frame_done, busy, data_ready} !== {e.d, e.fd, exp_busy, ~exp_busy}) begin
                n_err++;
                $display("FAIL back_to_back bit%0d: got %b want %b", i,
                         {dout, frame_done, busy, data_ready}, {e.d, e.fd, exp_busy, ~exp_busy});
            end
            if (i == 15) data_valid = 1'b0;
        end
    endtask

    task automatic test_busy_ignore();
        exp_t e;
        @(negedge clk);
        data_in = 8'h5A; data_valid = 1'b1;
        @(posedge clk);
        push_frame(8'h5A, 1'b1);
        @(negedge clk);
        data_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if ({dout, frame_done, busy} !== {e.d, e.fd, 1'b1}) begin
                n_err++;
                $display("FAIL busy_ignore bit%0d: got %b want %b", i,
                         {dout, frame_done, busy}, {e.d, e.fd, 1'b1});
            end
            if (i >= 4 && i <= 11) begin
                data_valid = i[0];
                data_in    = 8'($urandom);
            end else if (i == 12) begin
                data_valid = 1'b0;
            end
        end
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if ({dout, busy, data_ready} !== 3'b001) begin
                n_err++;
                $display("FAIL busy_ignore extra_frame: got dout/busy/ready=%b want 001",
                         {dout, busy, data_ready});
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [3:0] h;
        int det;
        @(negedge clk);
        data_in = 8'hF0; data_valid = 1'b1;
        @(posedge clk);
        push_frame(8'hF0, 1'b1);
        @(negedge clk);
        data_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (dout !== e.d) begin
                n_err++;
                $display("FAIL reset_mid pre bit%0d: got %b want %b", i, dout, e.d);
            end
        end
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        n_vec++;
        if ({dout, busy, data_ready, frame_done} !== 4'b0010) begin
            n_err++;
            $display("FAIL reset_mid abort: got dout/busy/ready/done=%b want 0010",
                     {dout, busy, data_ready, frame_done});
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if ({dout, busy, frame_done} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_mid quiet: got dout/busy/done=%b want 000",
                         {dout, busy, frame_done});
            end
        end
        h = 4'b0; det = 0;
        data_in = 8'hF0; data_valid = 1'b1;
        @(posedge clk);
        push_frame(8'hF0, 1'b1);
        @(negedge clk);
        data_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            h = {h[2:0], dout};
            if (h == MARKER) begin det++; h = 4'b0; end
            if (i < 14) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({dout, frame_done} !== {e.d, e.fd}) begin
                    n_err++;
                    $display("FAIL reset_mid fresh bit%0d: got %b want %b", i,
                             {dout, frame_done}, {e.d, e.fd});
                end
            end
        end
        n_vec++;
        if (det != 1) begin
            n_err++;
            $display("FAIL reset_mid detect_count: got %0d want 1", det);
        end
    endtask

    initial begin
        test_reset();
        test_single(8'hA5, "single_A5");
        test_parity();
        test_no_parity();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
